soc_top_level: RTL and testbench
================================

Name: soc_top_level

Overview:
- Reduced SoC top that acts as a UART-driven memory monitor.
- Receives command frames on rxd and performs word writes and reads on the shared 32-bit SRAM bus (base/ext banks); read data is returned on txd.
- Flash interface is held idle and safe; gpio0 mirrors the last written data word.
- Sits at FPGA top level, between board pins and external SRAM/flash.

Parameters:
- CLKS_PER_BIT, 434, clk_in cycles per UART bit (50 MHz / 115200); benches use 3.
- SRAM_WAIT, 2, clock cycles oe_n/we_n stay asserted per SRAM access (min 1).

Ports:
- clk_in  in  1  system clock, 50 MHz.
- rst_in_n  in  1  reset, asynchronous, active-low.
- rxd  in  1  UART receive, 8N1, idle high.
- txd  out  1  UART transmit, 8N1, idle high.
- ram_data  inout  32  shared SRAM data bus; high-Z except during writes.
- base_ram_addr  out  20  base bank word address.
- base_ram_ce_n / base_ram_oe_n / base_ram_we_n  out  1 each  base bank strobes, active-low.
- ext_ram_addr  out  20  ext bank word address.
- ext_ram_ce_n / ext_ram_oe_n / ext_ram_we_n  out  1 each  ext bank strobes, active-low.
- flash_data  inout  16  always high-Z.
- flash_address  out  24  constant 0.
- flash_ce  out  3  constant 0 (deselected).
- flash_rp_n / flash_vpen / flash_byte_n / flash_oe_n / flash_we_n  out  1 each  constant 1.
- gpio0  inout  32  driven with last written data word.
- gpio1  inout  32  input only, never driven (sampled, unused).

Behaviour:
- Reset:
  - rst_in_n asserts an internal rst_n asynchronously.
  - Deassertion is synchronised through 2 flops on clk_in.
  - While in reset: txd=1, all ce_n/oe_n/we_n=1, addresses=0, ram_data Z, gpio0=0, FSM=IDLE, receive/transmit state cleared.
  - Reset mid-operation aborts any command; no partial SRAM write completes after reset.
- UART RX:
  - Start bit is a falling edge on the 2-flop-synchronised rxd.
  - Each bit is sampled at mid-bit (CLKS_PER_BIT/2 after the edge, then every CLKS_PER_BIT), LSB first.
  - Stop bit must be 1, otherwise the byte is discarded.
  - Valid byte produces a 1-cycle rx_valid pulse.
- UART TX:
  - Start bit, 8 data bits LSB first, then 1 stop bit, each CLKS_PER_BIT long.
  - Accepts the next byte only when idle.
- Words are 4 bytes, little-endian (first byte = bits 7:0).
- Address mapping: command address A (word index); A[20]=0 selects base bank, A[20]=1 selects ext bank; A[19:0] drives the selected bank address. A[31:21] ignored.
- Command protocol, FSM states IDLE, W_ADDR, W_CNT, W_DATA, SRAM_WR, R_ADDR, SRAM_RD, TX:
  - IDLE, byte 0x30 -> W_ADDR (4 bytes) -> W_CNT (4 bytes, N).
    - N=0 returns to IDLE.
    - Otherwise, for each of N words: W_DATA (4 bytes) -> SRAM_WR at A+i.
    - After the Nth write -> IDLE. No reply.
  - IDLE, byte 0x34 -> R_ADDR (4 bytes) -> SRAM_RD at A -> TX of 4 bytes little-endian -> IDLE.
  - Any other byte in IDLE is ignored.
  - Bytes received during SRAM_RD/TX are dropped.
- SRAM write cycle:
  - Cycle 0: drive address, data and ce_n=0 for the selected bank.
  - Cycles 1..SRAM_WAIT: we_n=0.
  - Next cycle: we_n=1, data still driven, then release bus and ce_n=1.
  - oe_n stays 1 throughout.
- SRAM read cycle:
  - Address, ce_n=0 and oe_n=0 held for SRAM_WAIT+1 cycles.
  - ram_data captured on the last cycle; then oe_n=1, ce_n=1.
- The unselected bank stays fully deasserted. Only one bank is active at any time.
- gpio0 updates to the data word on each SRAM write (registered, 1 cycle after write start).
- Address increment wraps modulo 2^32; the bank is re-evaluated per word.

Test Plan:
- Reset: hold rst_in_n=0 41 ns, release -> internal rst_n rises within 2 clocks; txd=1, all strobes high, ram_data Z, flash_ce=0.
- Write: send 0x30, then words 0x00005566, 0x00000001, 0x3403eeff (CLKS_PER_BIT=3) -> one base-bank write, addr 0x05566, data 0x3403eeff, we_n low SRAM_WAIT cycles; gpio0=0x3403eeff.
- Read back: send 0x34, then 0x00005566 -> one read at base addr 0x05566; txd emits 0xff,0xee,0x03,0x34.
- Multi/ext: 0x30, addr 0x00100000, count 2, data 0x11111111, 0x22222222 -> ext bank writes at 0x00000 and 0x00001; base strobes stay high.
- Edge cases:
  - Count 0 -> no SRAM activity, return to IDLE; a following 0x34 is accepted.
  - Unknown byte 0x55 -> ignored.
  - Frame with stop bit 0 -> discarded.
- Reset mid-write (during W_DATA) -> no write strobe; FSM returns to IDLE.

Source files
------------

// File: rtl/soc_top_level.sv
// UART-driven SRAM monitor: 0x30 writes N words starting at word address A, 0x34 reads one word
// and returns it little-endian on txd. Flash is parked idle, gpio0 mirrors the last written word.
`timescale 1ns / 1ps
module soc_top_level #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SRAM_WAIT    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        rxd,
  output logic        txd,
  inout  wire  [31:0] ram_data,
  output logic [19:0] base_ram_addr,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  output logic [19:0] ext_ram_addr,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  inout  wire  [15:0] flash_data,
  output logic [23:0] flash_address,
  output logic [2:0]  flash_ce,
  output logic        flash_rp_n,
  output logic        flash_vpen,
  output logic        flash_byte_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  inout  wire  [31:0] gpio0,
  inout  wire  [31:0] gpio1
);

  localparam int unsigned BW   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned CW   = $clog2(SRAM_WAIT + 2);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [BW-1:0] HalfLoad = BW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BW-1:0] BitLoad  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle, StWAddr, StWCnt, StWData, StSramWr, StRAddr, StSramRd, StTx
  } state_e;

  // Reset asserts asynchronously, releases synchronously after two clk_in edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // UART receiver
  logic [1:0]    rx_sync_q;
  logic          rx_s, rx_last_q, rx_busy_q, rx_valid_q;
  logic [BW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      rx_last_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rxd};
      rx_last_q  <= rx_s;
      rx_valid_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_last_q && !rx_s) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= HalfLoad;
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= BitLoad;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0 && rx_s) begin
          rx_busy_q <= 1'b0;  // start bit gone by mid-bit: treat as a glitch
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_valid_q <= rx_s;
        end else if (rx_bit_q != 4'd0) begin
          rx_shift_q <= {rx_s, rx_shift_q[7:1]};
        end
      end
    end
  end

  // UART transmitter
  logic          tx_start, tx_busy_q;
  logic [7:0]    tx_byte;
  logic [BW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_shift_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_q  <= 1'b1;
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        tx_shift_q <= {1'b1, tx_byte, 1'b0};
      end
    end else if (tx_cnt_q != BitLoad) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      else                  tx_bit_q  <= tx_bit_q + 4'd1;
    end
  end
  assign txd = tx_busy_q ? tx_shift_q[0] : 1'b1;

  // Command FSM
  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d, tx_idx_q, tx_idx_d;
  logic [31:0]   word_q, word_d, addr_q, addr_d, cnt_q, cnt_d;
  logic [31:0]   data_q, data_d, rd_q, rd_d, gpio_q, gpio_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [31:0]   word_full;
  logic          frame_done;

  assign word_full  = {rx_shift_q, word_q[31:8]};
  assign frame_done = rx_valid_q && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      tx_idx_q   <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      gpio_q     <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tx_idx_q   <= tx_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      gpio_q     <= gpio_d;
      cyc_q      <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tx_idx_d   = tx_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    rd_d       = rd_q;
    gpio_d     = gpio_q;
    cyc_d      = cyc_q;
    tx_start   = 1'b0;
    tx_byte    = rd_q[{tx_idx_q, 3'b000} +: 8];
    if (rx_valid_q && (state_q inside {StWAddr, StWCnt, StWData, StRAddr})) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_d     = word_full;
    end
    unique case (state_q)
      StIdle: begin
        byte_cnt_d = '0;
        if (rx_valid_q && rx_shift_q == 8'h30) state_d = StWAddr;
        if (rx_valid_q && rx_shift_q == 8'h34) state_d = StRAddr;
      end
      StWAddr: if (frame_done) begin
        addr_d  = word_full;
        state_d = StWCnt;
      end
      StWCnt: if (frame_done) begin
        cnt_d   = word_full;
        state_d = (word_full == '0) ? StIdle : StWData;
      end
      StWData: if (frame_done) begin
        data_d  = word_full;
        cyc_d   = '0;
        state_d = StSramWr;
      end
      StSramWr: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == '0) gpio_d = data_q;
        if (cyc_q == CW'(SRAM_WAIT + 1)) begin
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q - 32'd1;
          state_d = (cnt_q == 32'd1) ? StIdle : StWData;
        end
      end
      StRAddr: if (frame_done) begin
        addr_d  = word_full;
        cyc_d   = '0;
        state_d = StSramRd;
      end
      StSramRd: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CW'(SRAM_WAIT)) begin
          rd_d     = ram_data;
          tx_idx_d = '0;
          state_d  = StTx;
        end
      end
      StTx: if (!tx_busy_q) begin
        tx_start = 1'b1;
        tx_idx_d = tx_idx_q + 2'd1;
        if (tx_idx_q == 2'd3) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM strobes: only the bank picked by addr_q[20] is ever enabled.
  logic wr_act, rd_act, we_on, base_on, ext_on;
  assign wr_act  = (state_q == StSramWr);
  assign rd_act  = (state_q == StSramRd);
  assign we_on   = wr_act && (cyc_q != '0) && (cyc_q <= CW'(SRAM_WAIT));
  assign base_on = (wr_act || rd_act) && !addr_q[20];
  assign ext_on  = (wr_act || rd_act) && addr_q[20];

  assign base_ram_addr = base_on ? addr_q[19:0] : '0;
  assign base_ram_ce_n = !base_on;
  assign base_ram_oe_n = !(base_on && rd_act);
  assign base_ram_we_n = !(base_on && we_on);
  assign ext_ram_addr  = ext_on ? addr_q[19:0] : '0;
  assign ext_ram_ce_n  = !ext_on;
  assign ext_ram_oe_n  = !(ext_on && rd_act);
  assign ext_ram_we_n  = !(ext_on && we_on);
  assign ram_data      = wr_act ? data_q : 32'bz;

  assign flash_data    = 16'bz;
  assign flash_address = '0;
  assign flash_ce      = '0;
  assign flash_rp_n    = 1'b1;
  assign flash_vpen    = 1'b1;
  assign flash_byte_n  = 1'b1;
  assign flash_oe_n    = 1'b1;
  assign flash_we_n    = 1'b1;
  assign gpio0         = gpio_q;

  logic unused_inputs;
  assign unused_inputs = ^{gpio1, flash_data};

endmodule

// File: tb/tb_soc_top_level.sv
// Scoreboard bench for soc_top_level: a word-level memory model predicts SRAM events and UART
// reply bytes; independent monitors pop and compare as the DUT produces them.
`timescale 1ns / 1ps
module tb_soc_top_level;

  localparam int CPB = 3;
  localparam int SW  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;
  wire  [31:0] ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  wire  [15:0] flash_data;
  logic [23:0] flash_address;
  logic [2:0]  flash_ce;
  logic        flash_rp_n, flash_vpen, flash_byte_n, flash_oe_n, flash_we_n;
  wire  [31:0] gpio0, gpio1;

  always #10 clk_in = ~clk_in;

  soc_top_level #(.CLKS_PER_BIT(CPB), .SRAM_WAIT(SW)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .rxd(rxd), .txd(txd), .ram_data(ram_data),
    .base_ram_addr(base_ram_addr), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_addr(ext_ram_addr), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .flash_data(flash_data), .flash_address(flash_address), .flash_ce(flash_ce),
    .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen), .flash_byte_n(flash_byte_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .gpio0(gpio0), .gpio1(gpio1)
  );

  typedef struct {logic [20:0] key; logic [31:0] data;} wr_t;
  wr_t         wr_q[$];
  logic [20:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] ref_mem[logic [20:0]];
  logic [31:0] sram[logic [20:0]];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // External SRAM: answers reads from what the DUT actually wrote.
  logic [31:0] sram_rd_val = '0;
  logic        sram_oe;
  assign sram_oe  = !base_ram_oe_n || !ext_ram_oe_n;
  assign ram_data = sram_oe ? sram_rd_val : 32'bz;
  assign gpio1    = 32'h0;

  logic we_prev = 1'b0, oe_prev = 1'b0;
  int   we_len = 0, oe_len = 0;
  always @(negedge clk_in) begin
    logic        we_low, bank;
    logic [20:0] key, rkey;
    wr_t         e;
    we_low = !base_ram_we_n || !ext_ram_we_n;
    bank   = !ext_ram_ce_n;
    key    = {bank, bank ? ext_ram_addr : base_ram_addr};
    if (we_low && !we_prev) begin
      we_len = 1;
      sram[key] = ram_data;
      if (wr_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got key 0x%0h data 0x%0h, expected none", key, ram_data);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", key, e.key);
        check("wr_data", ram_data, e.data);
        check("gpio0", gpio0, e.data);
        check("wr_strobes", {base_ram_ce_n, ext_ram_ce_n, base_ram_oe_n, ext_ram_oe_n},
              e.key[20] ? 4'b1011 : 4'b0111);
      end
    end else if (we_low) begin
      we_len++;
    end else if (we_prev) begin
      check("we_len", we_len, SW);
    end
    we_prev = we_low;

    if (sram_oe && !oe_prev) begin
      oe_len = 1;
      sram_rd_val = sram.exists(key) ? sram[key] : 32'h0;
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_read: got key 0x%0h, expected none", key);
      end else begin
        rkey = rd_q.pop_front();
        check("rd_addr", key, rkey);
        check("rd_strobes", {base_ram_ce_n, ext_ram_ce_n, base_ram_we_n, ext_ram_we_n},
              rkey[20] ? 4'b1011 : 4'b0111);
      end
    end else if (sram_oe) begin
      oe_len++;
    end else if (oe_prev) begin
      check("oe_len", oe_len, SW + 1);
    end
    oe_prev = sram_oe;
  end

  // UART reply monitor
  initial begin
    logic [7:0] b;
    logic       stop_b;
    forever begin
      @(negedge clk_in);
      if (txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_in);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk_in);
        stop_b = txd;
        check("tx_stop", stop_b, 1'b1);
        if (tx_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_tx: got 0x%0h, expected none", b);
        end else begin
          check("tx_byte", b, tx_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    @(negedge clk_in);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    rxd = stop_b;
    repeat (CPB) @(negedge clk_in);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk_in);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((wr_q.size() + rd_q.size() + tx_q.size()) != 0 && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    n_vec++;
    if (t >= 2000) begin
      n_err++;
      $display("FAIL idle_timeout: got %0d events outstanding, expected 0",
               wr_q.size() + rd_q.size() + tx_q.size());
      wr_q.delete(); rd_q.delete(); tx_q.delete();
    end
    repeat (4 * CPB) @(negedge clk_in);
  endtask

  // Reference model: word i of a write lands at (A+i) mod 2^32, bank = bit 20.
  task automatic cmd_write(input logic [31:0] a, input logic [31:0] w[$]);
    logic [31:0] ai;
    send_byte(8'h30, 1'b1);
    send_word(a);
    send_word(32'(w.size()));
    foreach (w[i]) begin
      ai = a + 32'(i);
      wr_q.push_back('{key: ai[20:0], data: w[i]});
      ref_mem[ai[20:0]] = w[i];
      send_word(w[i]);
    end
    wait_idle();
  endtask

  task automatic cmd_read(input logic [31:0] a);
    logic [31:0] v;
    v = ref_mem.exists(a[20:0]) ? ref_mem[a[20:0]] : 32'h0;
    rd_q.push_back(a[20:0]);
    for (int i = 0; i < 4; i++) tx_q.push_back(v[8*i +: 8]);
    send_byte(8'h34, 1'b1);
    send_word(a);
    wait_idle();
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] used[$];
    logic [31:0] a;
    logic [7:0]  junk;
    #1 rst_in_n = 1'b0;
    #34;
    check("rst_txd", txd, 1'b1);
    check("rst_strobes", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                          ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 6'h3f);
    check("rst_addr", {base_ram_addr, ext_ram_addr}, 40'h0);
    check("rst_gpio0", gpio0, 32'h0);
    check("flash_ce", flash_ce, 3'b000);
    check("flash_addr", flash_address, 24'h0);
    check("flash_ctl", {flash_rp_n, flash_vpen, flash_byte_n, flash_oe_n, flash_we_n}, 5'h1f);
    #7 rst_in_n = 1'b1;
    repeat (4) @(negedge clk_in);

    w = '{32'h3403eeff};
    cmd_write(32'h00005566, w);
    check("gpio0_hold", gpio0, 32'h3403eeff);
    cmd_read(32'h00005566);
    w = '{32'h11111111, 32'h22222222};
    cmd_write(32'h00100000, w);
    w.delete();
    cmd_write(32'h00001234, w);
    cmd_read(32'h00100001);
    send_byte(8'h55, 1'b1);
    cmd_read(32'h00100000);
    send_byte(8'h30, 1'b0);
    repeat (4 * CPB) @(negedge clk_in);
    cmd_read(32'h00005566);
    w = '{32'hcafef00d, 32'h0badbeef};
    cmd_write(32'h000fffff, w);
    cmd_read(32'h00100000);
    w = '{32'h5a5a1234, 32'h87654321};
    cmd_write(32'hffffffff, w);
    cmd_read(32'h00000000);
    cmd_read(32'hffffffff);

    // Reset in the middle of a data word: the write must never reach the SRAM.
    send_byte(8'h30, 1'b1);
    send_word(32'h00000010);
    send_word(32'h00000001);
    send_byte(8'hab, 1'b1);
    send_byte(8'hcd, 1'b1);
    rst_in_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("midrst_strobes", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                             ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 6'h3f);
    check("midrst_txd", txd, 1'b1);
    rst_in_n = 1'b1;
    repeat (4) @(negedge clk_in);
    cmd_read(32'h00000010);

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          w.delete();
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) w.push_back($urandom);
          a = {11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
               20'($urandom_range(0, 15))};
          used.push_back(a);
          cmd_write(a, w);
        end
        1: begin
          if (used.size() != 0 && $urandom_range(0, 1) == 1)
            a = used[$urandom_range(0, used.size() - 1)];
          else
            a = $urandom;
          cmd_read(a);
        end
        default: begin
          junk = 8'($urandom);
          while (junk == 8'h30 || junk == 8'h34) junk = 8'($urandom);
          send_byte(junk, 1'b1);
          repeat (4 * CPB) @(negedge clk_in);
        end
      endcase
    end

    check("left_wr", wr_q.size(), 0);
    check("left_rd", rd_q.size(), 0);
    check("left_tx", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule
